piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out converter. Words arrive on a valid/ready
// handshake and leave one bit per clock on ser_out. The serial stream feeds
// the din input of a downstream sequence detector. A one-entry hold register
// lets the producer hand over the next word while the current one is still
// shifting, so consecutive words come out with no gap between them.
//
// Parameters
//   WIDTH      word width in bits, 2..32
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_data    parallel word from the producer
//   in_valid   in_data holds a word
//   in_ready   a word can be accepted this cycle
//   ser_out    serial bit stream
//   ser_valid  ser_out carries a payload bit this cycle
//   word_done  pulse coincident with the last bit of each word
//   busy       a word is shifting out or waiting in the hold register
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdValid;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_lastBit;
  logic             w_loadIn;
  logic             w_loadHold;
  logic             w_captureHold;
  logic             w_advance;
  logic             w_drain;
  logic             w_curBit;
  logic [WIDTH-1:0] w_shifted;

  // The producer may hand over a word only while the hold slot is free.
  // Gating with rst keeps words offered during reset from being taken.
  assign in_ready  = ~r_holdValid & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST_IDX);

  // The bit on the wire is always taken from the leaving end of the shifter,
  // and the shift direction moves the next bit into that position.
  generate
    if (MSB_FIRST) begin : g_msbFirst
      assign w_curBit  = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsbFirst
      assign w_curBit  = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath control decode. On the last bit of a word the
  // shifter is refilled in the same edge, first from the hold register and
  // otherwise straight from the input, so back-to-back words never leave an
  // empty cycle. A word arriving mid-word can only go to the hold slot,
  // because in_ready is low whenever that slot is already occupied.
  always_comb begin
    w_nextState   = r_state;
    w_loadIn      = 1'b0;
    w_loadHold    = 1'b0;
    w_captureHold = 1'b0;
    w_advance     = 1'b0;
    w_drain       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_loadIn    = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_lastBit) begin
          w_advance     = 1'b1;
          w_captureHold = w_accept;
        end else if (r_holdValid) begin
          w_loadHold = 1'b1;
        end else if (w_accept) begin
          w_loadIn = 1'b1;
        end else begin
          w_drain     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Shifter, bit counter and hold register. The counter restarts at zero on
  // every load, so it always holds the index of the bit currently on the
  // wire. Draining clears the shifter so an idle block holds no stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_holdValid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_loadIn) begin
        r_shift <= in_data;
        r_cnt   <= '0;
      end else if (w_loadHold) begin
        r_shift     <= r_hold;
        r_cnt       <= '0;
        r_holdValid <= 1'b0;
      end else if (w_advance) begin
        r_shift <= w_shifted;
        r_cnt   <= r_cnt + CW'(1);
      end else if (w_drain) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end
      if (w_captureHold) begin
        r_hold      <= in_data;
        r_holdValid <= 1'b1;
      end
    end
  end

  // Outputs decode only registered state, so nothing on in_* can reach the
  // serial side within the same cycle.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    word_done = 1'b0;
    if (r_state == SHIFT) begin
      ser_out   = w_curBit;
      ser_valid = 1'b1;
      word_done = (r_cnt == LAST_IDX);
    end
    busy = (r_state == SHIFT) | r_holdValid;
  end

endmodule
